// File: rtl/pet_video_pkg.sv
// Shared constants for the PET video path: character geometry, pipeline depth
// and the character ROM address field layout.
package pet_video_pkg;

  localparam int PIX_PER_CHAR  = 8;
  localparam int PIPE_PIX      = 16;
  localparam int CROM_GFX_W    = 1;
  localparam int CROM_CODE_W   = 7;
  localparam int CROM_ROW_W    = 3;
  localparam int CROM_FIELDS_W = CROM_GFX_W + CROM_CODE_W + CROM_ROW_W;
  localparam int TIMING_W      = 5;

  typedef struct packed {
    logic [PIX_PER_CHAR-1:0] bits;
    logic                    inv;
    logic                    de;
  } glyph_t;

  function automatic logic pix_bit(input logic msb, input logic inv, input logic blank);
    return (msb ^ inv) & ~blank;
  endfunction

endpackage

// File: rtl/pet_pixel_shifter_if.sv
// Memory-side bus of the pixel shifter: VRAM and character ROM address/data.
interface pet_pixel_shifter_if #(
  parameter int VRAM_AW = 11,
  parameter int CROM_AW = 11
);
  logic [VRAM_AW-1:0] video_addr;
  logic [7:0]         video_data;
  logic [CROM_AW-1:0] charaddr;
  logic [7:0]         chardata;

  modport master (output video_addr, charaddr, input video_data, chardata);
  modport slave  (input video_addr, charaddr, output video_data, chardata);
endinterface

// File: rtl/pet_video_delay.sv
// Fixed-depth delay line for video timing bits, advanced only on the pixel enable.
module pet_video_delay #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (ce) line_d = {line_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (reset) line_q <= '0;
    else       line_q <= line_d;
  end

  assign dout = line_q[DEPTH-1];
endmodule

// File: rtl/pet_pixel_shifter.sv
// PET character pixel shifter: VRAM -> char ROM fetch, two-slot pipeline, serial pixels.
// Define PET_PIXEL_CURSOR_EN to invert characters flagged by vid_cursor.
module pet_pixel_shifter
  import pet_video_pkg::*;
#(
  parameter int VRAM_AW = 11,
  parameter int CROM_AW = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce_pix,
  input  logic                ce_char,
  input  logic [13:0]         vid_ma,
  input  logic [4:0]          vid_ra,
  input  logic                vid_de,
  input  logic                vid_cursor,
  input  logic                vid_hsync,
  input  logic                vid_vsync,
  input  logic                vid_hblank,
  input  logic                vid_vblank,
  input  logic                video_blank,
  input  logic                video_gfx,
  pet_pixel_shifter_if.master mem,
  output logic                pix,
  output logic                de_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblank_out,
  output logic                vblank_out
);
  logic                     slot_start;
  logic [VRAM_AW-1:0]       video_addr_q, video_addr_d;
  logic [CROM_ROW_W-1:0]    ra1_q, ra1_d;
  logic                     de1_q, de1_d;
  logic                     fetch1_q, fetch1_d, fetch2_q, fetch2_d;
  logic [CROM_FIELDS_W-1:0] crom_fields;
  logic [CROM_AW-1:0]       charaddr_q, charaddr_d;
  logic                     invf_q, invf_d;
  glyph_t                   stage2_q, stage2_d, hold_q, hold_d;
  logic [PIX_PER_CHAR-1:0]  shift_q, shift_d;
  logic                     inv_q, inv_d, load_inv;
  logic                     pix_q, pix_d;
  logic [TIMING_W-1:0]      tim_dly, tim_q, tim_d;
  logic                     unused_inputs;

`ifdef PET_PIXEL_CURSOR_EN
  logic cur1_q, cur1_d, cur2_q, cur2_d, curh_q, curh_d;

  always_comb begin
    cur1_d = cur1_q;
    cur2_d = cur2_q;
    curh_d = curh_q;
    if (slot_start) cur1_d = vid_cursor;
    if (fetch2_q)   cur2_d = cur1_q;
    if (slot_start) curh_d = cur2_q;
    load_inv = hold_q.inv ^ curh_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur1_q <= 1'b0;
      cur2_q <= 1'b0;
      curh_q <= 1'b0;
    end else begin
      cur1_q <= cur1_d;
      cur2_q <= cur2_d;
      curh_q <= curh_d;
    end
  end

  assign unused_inputs = &{1'b0, vid_ma[13:VRAM_AW], vid_ra[4:CROM_ROW_W]};
`else
  assign load_inv      = hold_q.inv;
  assign unused_inputs = &{1'b0, vid_ma[13:VRAM_AW], vid_ra[4:CROM_ROW_W], vid_cursor};
`endif

  assign slot_start  = ce_pix & ce_char;
  assign crom_fields = {video_gfx, mem.video_data[CROM_CODE_W-1:0], ra1_q};

  pet_video_delay #(.WIDTH(TIMING_W), .DEPTH(PIPE_PIX)) u_timing_delay (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_pix),
    .din   ({vid_hsync, vid_vsync, vid_hblank, vid_vblank, vid_de}),
    .dout  (tim_dly)
  );

  always_comb begin
    video_addr_d = video_addr_q;
    ra1_d        = ra1_q;
    de1_d        = de1_q;
    fetch1_d     = slot_start;
    fetch2_d     = fetch1_q;
    charaddr_d   = charaddr_q;
    invf_d       = invf_q;
    stage2_d     = stage2_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    inv_d        = inv_q;
    pix_d        = pix_q;
    tim_d        = tim_q;

    // Stage 1: latch the slot's matrix address and attributes
    if (slot_start) begin
      video_addr_d = vid_ma[VRAM_AW-1:0];
      ra1_d        = vid_ra[CROM_ROW_W-1:0];
      de1_d        = vid_de;
    end
    // VRAM data -> ROM address, one clk later
    if (fetch1_q) begin
      charaddr_d = CROM_AW'(crom_fields);
      invf_d     = mem.video_data[7];
    end
    // Stage 2: ROM data captured, two clk after the latch
    if (fetch2_q) stage2_d = '{bits: mem.chardata, inv: invf_q, de: de1_q};

    // Hold register and shifter both advance a full character per slot start
    if (slot_start) begin
      hold_d  = stage2_q;
      shift_d = hold_q.de ? hold_q.bits : '0;
      inv_d   = hold_q.de & load_inv;
    end else if (ce_pix) begin
      shift_d = {shift_q[PIX_PER_CHAR-2:0], 1'b0};
    end

    // Output stage: pixel taken from the value entering the shifter so it lines up with timing
    if (ce_pix) begin
      pix_d = pix_bit(shift_d[PIX_PER_CHAR-1], inv_d, video_blank);
      tim_d = tim_dly;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      video_addr_q <= '0;
      ra1_q        <= '0;
      de1_q        <= 1'b0;
      fetch1_q     <= 1'b0;
      fetch2_q     <= 1'b0;
      charaddr_q   <= '0;
      invf_q       <= 1'b0;
      stage2_q     <= '0;
      hold_q       <= '0;
      shift_q      <= '0;
      inv_q        <= 1'b0;
      pix_q        <= 1'b0;
      tim_q        <= '0;
    end else begin
      video_addr_q <= video_addr_d;
      ra1_q        <= ra1_d;
      de1_q        <= de1_d;
      fetch1_q     <= fetch1_d;
      fetch2_q     <= fetch2_d;
      charaddr_q   <= charaddr_d;
      invf_q       <= invf_d;
      stage2_q     <= stage2_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      inv_q        <= inv_d;
      pix_q        <= pix_d;
      tim_q        <= tim_d;
    end
  end

  assign mem.video_addr = video_addr_q;
  assign mem.charaddr   = charaddr_q;
  assign pix            = pix_q;
  assign {hsync_out, vsync_out, hblank_out, vblank_out, de_out} = tim_q;
endmodule

// File: tb/tb_pet_pixel_shifter.sv
// Directed bench for pet_pixel_shifter: VRAM/ROM models, per-ce_pix output logs, fixed expectations.
module tb_pet_pixel_shifter;
  logic        clk = 1'b0;
  logic        reset, ce_pix, ce_char;
  logic [13:0] vid_ma;
  logic [4:0]  vid_ra;
  logic        vid_de, vid_cursor, vid_hsync, vid_vsync, vid_hblank, vid_vblank;
  logic        video_blank, video_gfx;
  logic        pix, de_out, hsync_out, vsync_out, hblank_out, vblank_out;

  pet_pixel_shifter_if #(.VRAM_AW(11), .CROM_AW(11)) mem ();

  logic [7:0] vram [2048];
  logic [7:0] crom [2048];
  assign mem.video_data = vram[mem.video_addr];
  assign mem.chardata   = crom[mem.charaddr];

  pet_pixel_shifter #(.VRAM_AW(11), .CROM_AW(11)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .ce_char(ce_char),
    .vid_ma(vid_ma), .vid_ra(vid_ra), .vid_de(vid_de), .vid_cursor(vid_cursor),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_hblank(vid_hblank), .vid_vblank(vid_vblank),
    .video_blank(video_blank), .video_gfx(video_gfx), .mem(mem),
    .pix(pix), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblank_out(hblank_out), .vblank_out(vblank_out)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cnt, hs_lo, hs_hi, blank_from, rst_at, hs_count;
  logic       de_en, stray;
  logic [7:0] want_byte;
  logic       pix_log [200];
  logic       hs_log  [200];
  logic       de_log  [200];
  logic [10:0] va_log [200];
  logic [10:0] ca_log [200];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One character-clock pixel: ce_pix for one clk, then three idle clks.
  task automatic tick();
    vid_ma      = 14'(cnt / 8);
    vid_de      = de_en;
    vid_hsync   = (cnt >= hs_lo) && (cnt <= hs_hi);
    video_blank = (cnt >= blank_from);
    reset       = (cnt == rst_at);
    ce_pix      = 1'b1;
    ce_char     = (cnt % 8 == 0);
    @(posedge clk); #1;
    ce_pix      = 1'b0;
    reset       = 1'b0;
    ce_char     = stray;
    pix_log[cnt] = pix;
    hs_log[cnt]  = hsync_out;
    de_log[cnt]  = de_out;
    va_log[cnt]  = mem.video_addr;
    repeat (3) @(posedge clk);
    #1;
    ce_char     = 1'b0;
    ca_log[cnt] = mem.charaddr;
    cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; ce_pix = 1'b0; ce_char = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 0;
  endtask

  task automatic clear_vram();
    for (int i = 0; i < 2048; i++) vram[i] = 8'h00;
  endtask

  initial begin
    vid_ma = '0; vid_ra = '0; vid_de = 1'b0; vid_cursor = 1'b0;
    vid_hsync = 1'b0; vid_vsync = 1'b0; vid_hblank = 1'b0; vid_vblank = 1'b0;
    video_blank = 1'b0; video_gfx = 1'b0; ce_pix = 1'b0; ce_char = 1'b0; reset = 1'b0;
    hs_lo = 1000; hs_hi = -1; blank_from = 1000; rst_at = -1; de_en = 1'b1; stray = 1'b0;
    for (int i = 0; i < 2048; i++) crom[i] = 8'h00;
    crom[8] = 8'hA5;   // gfx 0, code 0x01, row 0
    clear_vram();

    do_reset();
    chk("rst_pix", pix, 0);
    chk("rst_de_out", de_out, 0);
    chk("rst_hsync_out", hsync_out, 0);
    chk("rst_vsync_out", vsync_out, 0);
    chk("rst_hblank_out", hblank_out, 0);
    chk("rst_vblank_out", vblank_out, 0);
    chk("rst_video_addr", mem.video_addr, 0);
    chk("rst_charaddr", mem.charaddr, 0);

    // Normal video, stray ce_char pulses between pixel enables
    vram[0] = 8'h01; stray = 1'b1;
    run(24);
    stray = 1'b0;
    want_byte = 8'hA5;
    for (int i = 16; i < 24; i++) chk($sformatf("norm_pix%0d", i), pix_log[i], want_byte[23-i]);
    chk("norm_pix15", pix_log[15], 0);
    chk("norm_charaddr", ca_log[0], 11'h008);
    chk("norm_de_out15", de_log[15], 0);
    chk("norm_de_out16", de_log[16], 1);

    // Inverse video
    do_reset();
    vram[0] = 8'h81;
    run(24);
    want_byte = 8'h5A;
    for (int i = 16; i < 24; i++) chk($sformatf("inv_pix%0d", i), pix_log[i], want_byte[23-i]);
    chk("inv_charaddr", ca_log[0], 11'h008);

    // hsync delay alignment
    do_reset();
    clear_vram();
    hs_lo = 100; hs_hi = 131;
    run(150);
    chk("hs115", hs_log[115], 0);
    chk("hs116", hs_log[116], 1);
    chk("hs147", hs_log[147], 1);
    chk("hs148", hs_log[148], 0);
    hs_count = 0;
    for (int i = 0; i < 150; i++) hs_count += int'(hs_log[i]);
    chk("hs_width", hs_count, 32);
    hs_lo = 1000; hs_hi = -1;

    // Display disabled with nonzero data
    do_reset();
    vram[0] = 8'h01; de_en = 1'b0;
    run(24);
    for (int i = 16; i < 24; i++) chk($sformatf("de0_pix%0d", i), pix_log[i], 0);
    chk("de0_de_out16", de_log[16], 0);
    de_en = 1'b1;

    // video_blank mid-character; timing outputs unaffected
    do_reset();
    hs_lo = 0; hs_hi = 7; blank_from = 18;
    run(24);
    chk("blk_pix16", pix_log[16], 1);
    chk("blk_pix17", pix_log[17], 0);
    for (int i = 18; i < 24; i++) chk($sformatf("blk_pix%0d", i), pix_log[i], 0);
    for (int i = 18; i < 24; i++) chk($sformatf("blk_hs%0d", i), hs_log[i], 1);
    chk("blk_de_out18", de_log[18], 1);
    hs_lo = 1000; hs_hi = -1; blank_from = 1000;

    // Reset pulse at ce_pix 10 abandons in-flight characters
    do_reset();
    for (int i = 0; i < 8; i++) vram[i] = 8'h01;
    rst_at = 10;
    run(40);
    rst_at = -1;
    chk("mid_rst_video_addr", va_log[10], 0);
    chk("mid_rst_pix10", pix_log[10], 0);
    for (int i = 11; i < 32; i++) chk($sformatf("mid_rst_pix%0d", i), pix_log[i], 0);
    want_byte = 8'hA5;
    for (int i = 32; i < 40; i++) chk($sformatf("mid_rst_pix%0d", i), pix_log[i], want_byte[39-i]);

    // Cursor flag
    do_reset();
    clear_vram();
    vram[0] = 8'h01; vid_cursor = 1'b1;
    run(24);
    vid_cursor = 1'b0;
`ifdef PET_PIXEL_CURSOR_EN
    want_byte = 8'h5A;
`else
    want_byte = 8'hA5;
`endif
    for (int i = 16; i < 24; i++) chk($sformatf("cur_pix%0d", i), pix_log[i], want_byte[23-i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pet_pixel_shifter.md
PET_PIXEL_SHIFTER -- requirements
Module: pet_pixel_shifter

Interface
REQ-001 SHALL have parameter VRAM_AW, 11, video RAM address width.
REQ-002 SHALL have parameter CROM_AW, 11, character ROM address width, composed as gfx(1) + code(7) + row(3).
REQ-003 SHALL have these ports: clk  in  1  system clock; reset  in  1  synchronous, active-high.
REQ-004 SHALL have these ports: ce_pix  in  1  8 MHz pixel enable, min 3 clk apart; ce_char  in  1  character-slot start, meaningful only with ce_pix.
REQ-005 SHALL have these ports: vid_ma  in  14  matrix address; vid_ra  in  5  raster row; vid_de  in  1  display enable; vid_cursor  in  1  cursor flag.
REQ-006 SHALL have these ports: vid_hsync, vid_vsync, vid_hblank, vid_vblank  in  1 each  timing from generator.
REQ-007 SHALL have these ports: video_blank  in  1  force pixels off; video_gfx  in  1  charset select.
REQ-008 SHALL have these ports: video_addr  out  VRAM_AW  VRAM address; video_data  in  8  VRAM data, 1-clk latency; charaddr  out  CROM_AW  ROM address; chardata  in  8  ROM data, 1-clk latency.
REQ-009 SHALL have these ports: pix  out  1  serial pixel; de_out, hsync_out, vsync_out, hblank_out, vblank_out  out  1 each  aligned timing.

Function
REQ-010 SHALL act only on clk edges; pipeline advances only when ce_pix=1; ce_char with ce_pix=0 SHALL be ignored.
REQ-011 SHALL, at a slot start (ce_pix and ce_char), latch ma[VRAM_AW-1:0], ra[2:0], de, cursor into stage 1 and drive video_addr from the latch.
REQ-012 SHALL drive charaddr = {video_gfx, video_data[6:0], ra1[2:0]} 1 clk after the stage-1 latch, and capture inv = video_data[7] at that same clk.
REQ-013 SHALL capture chardata into stage 2 2 clk after the stage-1 latch; stage 2 holds fetched bits, inv, de and cursor.
REQ-014 SHALL, at the next slot start, move stage 2 into the output holding register; at the slot start after that, load the shifter.
REQ-015 SHALL load the shifter with de ? chardata : 8'h00 and inv with de ? inv : 0.
REQ-016 SHALL shift the shifter left one bit (MSB first, zero fill) on each ce_pix that is not a slot start.
REQ-017 SHALL register pix = (shift[7] ^ inv) & ~video_blank on each ce_pix.
REQ-018 SHALL place the first pixel of a slot-k character in the ce_pix of slot k+2 (latency 16 ce_pix, 2 character times).
REQ-019 SHALL delay hsync, vsync, hblank, vblank and de by exactly 16 ce_pix, so that they stay aligned with pix.
REQ-020 SHALL NOT let video_blank affect the sync, blank or de outputs.
REQ-021 SHALL treat a slot of any length other than 8 ce_pix (late or early ce_char) as a usage error; the shifter SHALL reload at every slot start regardless.

Reset
REQ-022 SHALL, on reset=1, clear the following to 0 on the next clk: pix, all *_out, video_addr, charaddr, shifter, inv, the stage registers and the delay line.
REQ-023 SHALL abandon any in-flight fetch when reset is asserted mid-operation; after release, outputs SHALL stay 0 until 16 ce_pix after the first slot start.

Configuration
REQ-024 SHALL, with macro PET_PIXEL_CURSOR_EN defined, XOR the latched cursor into inv, so a character with de and cursor shows inverted.
REQ-025 SHALL, without PET_PIXEL_CURSOR_EN, keep the vid_cursor port, ignore it, and generate no cursor logic.

Structure
REQ-026 SHALL have shared package pet_video_pkg hold PIX_PER_CHAR=8, PIPE_PIX=16, and the charaddr field widths.
REQ-027 SHALL implement the 16-stage, 5-bit timing delay as sub-module pet_video_delay (parameterised width/depth, advanced by ce_pix).

Verification
REQ-028 SHALL drive VRAM[0]=8'h01 with ROM(0x01,row 0)=8'hA5 at slot 0, de=1 -> pix sequence 1,0,1,0,0,1,0,1 in ce_pix 16..23.
REQ-029 SHALL drive VRAM[0]=8'h81 with the same ROM -> pix sequence 0,1,0,1,1,0,1,0 (inverse video).
REQ-030 SHALL pulse vid_hsync high in ce_pix 100..131 -> hsync_out high in ce_pix 116..147 exactly.
REQ-031 SHALL hold vid_de=0 with nonzero data -> pix=0 for the slot; video_blank=1 mid-char -> pix=0 from the next ce_pix while hsync_out is unaffected.
REQ-032 SHALL assert reset at ce_pix 10 for 1 clk -> all outputs 0; first nonzero pix no earlier than 16 ce_pix after the next slot start.
REQ-033 SHALL, with PET_PIXEL_CURSOR_EN, drive cursor=1 with char 8'h01 -> output inverted; without the macro -> output non-inverted.
